sel_mux_pipe: RTL and testbench



---
 rtl/sel_mux_pkg.sv | 38 +++
 rtl/sel_mux_stage.sv | 40 ++++
 rtl/sel_mux_pipe.sv | 108 ++++++++++
 tb/tb_sel_mux_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sel_mux_pkg.sv
// ============================================================================
// sel_mux_pkg : shared helpers and parameter checks for the selector pipeline
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sel_mux_pkg;

  // Ceiling log2, floored at 1 so a 2-input selector still gets a 1-bit select.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic int sel_w(input int num_in);
    return clog2(num_in);
  endfunction

  function automatic bit stages_ok(input int stages);
    return (stages == 1) || (stages == 2);
  endfunction

  function automatic bit num_in_ok(input int num_in);
    return (num_in >= 2) && (num_in <= 16);
  endfunction

  function automatic bit default_sel_ok(input int default_sel, input int num_in);
    return (default_sel >= 0) && (default_sel < num_in);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sel_mux_stage.sv
// ============================================================================
// sel_mux_stage : one valid/ready register slice (data + valid, no skid)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sel_mux_stage #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Accept when empty or when the held item leaves this cycle.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sel_mux_pipe.sv
// ============================================================================
// sel_mux_pipe : registered N:1 selector with latched select, range error
//                pulse and a 1- or 2-stage valid/ready output pipeline
// Revision     : 1.0
// ============================================================================
`default_nettype none

module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter  int WIDTH       = 3,
  parameter  int NUM_IN      = 4,
  parameter  int STAGES      = 1,
  parameter  int DEFAULT_SEL = 0,
  localparam int SEL_W       = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_load,
  output logic                    sel_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        dout,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if (!stages_ok(STAGES)) begin : g_bad_stages
    $error("sel_mux_pipe: STAGES must be 1 or 2");
  end
  if (!num_in_ok(NUM_IN)) begin : g_bad_num_in
    $error("sel_mux_pipe: NUM_IN must be in 2..16");
  end
  if (!default_sel_ok(DEFAULT_SEL, NUM_IN)) begin : g_bad_default_sel
    $error("sel_mux_pipe: DEFAULT_SEL must be below NUM_IN");
  end

  logic [SEL_W-1:0] sel_q;
  logic             sel_err_q;
  logic             sel_in_range;
  logic [WIDTH-1:0] slice;

  assign sel_in_range = int'(sel) < NUM_IN;
  assign sel_err      = sel_err_q;

  // A rejected load leaves sel_q alone and raises a single-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= SEL_W'(DEFAULT_SEL);
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_load && !sel_in_range;
      if (sel_load && sel_in_range) sel_q <= sel;
    end
  end

  always_comb begin
    slice = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_q == SEL_W'(k)) slice = din[k*WIDTH +: WIDTH];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             up_ready;
    logic             q_valid;
    logic [WIDTH-1:0] q_data;
    logic             dn_ready;

    if (i == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = slice;
    end else begin : g_chain
      assign up_valid = g_stage[i-1].q_valid;
      assign up_data  = g_stage[i-1].q_data;
    end

    if (i == STAGES - 1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_inner
      assign dn_ready = g_stage[i+1].up_ready;
    end

    sel_mux_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (up_valid),
      .in_data  (up_data),
      .in_ready (up_ready),
      .out_valid(q_valid),
      .out_data (q_data),
      .out_ready(dn_ready)
    );
  end

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[STAGES-1].q_valid;
  assign dout      = g_stage[STAGES-1].q_data;

endmodule

`default_nettype wire

// File: tb/tb_sel_mux_pipe.sv
// ============================================================================
// tb_sel_mux_pipe : directed + random checks of sel_mux_pipe against a
//                   latency-FIFO reference model (NUM_IN=5, STAGES=2)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_sel_mux_pipe;

  localparam int WIDTH       = 3;
  localparam int NUM_IN      = 5;
  localparam int STAGES      = 2;
  localparam int DEFAULT_SEL = 2;
  localparam int SEL_W       = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] din;
  logic [SEL_W-1:0]        sel;
  logic                    sel_load;
  logic                    sel_err;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        dout;
  logic                    out_valid;
  logic                    out_ready;

  always #5 clk = ~clk;

  sel_mux_pipe #(
    .WIDTH      (WIDTH),
    .NUM_IN     (NUM_IN),
    .STAGES     (STAGES),
    .DEFAULT_SEL(DEFAULT_SEL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .sel      (sel),
    .sel_load (sel_load),
    .sel_err  (sel_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int npass = 0;
  int ntot  = 0;

  // Model: items in flight as a FIFO, each tagged with its entry edge.
  int q_data[$];
  int q_t[$];
  int cyc    = 0;
  int sel_m  = DEFAULT_SEL;
  bit err_m  = 1'b0;
  int pushes = 0;

  function automatic int pick(input logic [NUM_IN*WIDTH-1:0] d, input int k);
    return (int'(d >> (k * WIDTH))) & 7;
  endfunction

  function automatic logic [NUM_IN*WIDTH-1:0] pack(input int a0, input int a1,
                                                   input int a2, input int a3, input int a4);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input bit v, input bit ld, input int s, input bit ordy,
                      input logic [NUM_IN*WIDTH-1:0] d);
    bit ov_e;
    bit ir_e;
    in_valid  = v;
    sel_load  = ld;
    sel       = SEL_W'(s);
    out_ready = ordy;
    din       = d;
    ov_e = (q_data.size() > 0) && ((cyc - q_t[0]) >= STAGES - 1);
    ir_e = (q_data.size() < STAGES) || ordy;
    @(negedge clk);
    chk("out_valid", out_valid, ov_e);
    if (ov_e) chk("dout", dout, q_data[0]);
    chk("in_ready", in_ready, ir_e);
    chk("sel_err", sel_err, err_m);
    @(posedge clk);
    cyc++;
    if (ov_e && ordy) begin
      void'(q_data.pop_front());
      void'(q_t.pop_front());
    end
    if (v && ir_e) begin
      q_data.push_back(pick(d, sel_m));
      q_t.push_back(cyc);
      pushes++;
    end
    err_m = ld && (s >= NUM_IN);
    if (ld && s < NUM_IN) sel_m = s;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_IN*WIDTH-1:0] d;
    rst_n = 1'b0; din = '0; sel = '0; sel_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sel_err", sel_err, 0);
    rst_n = 1'b1;

    // Default select picks input 2 -> 5
    d = pack(1, 3, 5, 7, 0);
    step(0, 0, 0, 1, d);
    step(1, 0, 0, 1, d);
    step(0, 0, 0, 1, d);
    step(0, 0, 0, 1, d);

    // Sweep every legal select, capturing right after each load
    d = pack(6, 1, 4, 2, 7);
    for (int k = 0; k < NUM_IN; k++) begin
      step(0, 1, k, 1, d);
      step(1, 0, 0, 1, d);
    end
    repeat (3) step(1, 0, 0, 1, d);

    // Out-of-range load keeps the previous select (4)
    step(0, 1, 6, 1, d);
    step(1, 0, 0, 1, d);
    step(0, 0, 0, 1, d);
    step(0, 0, 0, 1, d);

    // Load and capture together: capture uses the old select
    d = pack(4, 6, 0, 0, 0);
    step(0, 1, 0, 1, d);
    step(1, 1, 1, 1, d);
    step(1, 0, 0, 1, d);
    repeat (3) step(0, 0, 0, 1, d);

    // Backpressure: stream 1..4 with the consumer stalled for 3 cycles
    begin
      int base;
      int n;
      base = pushes;
      n = 0;
      while (pushes - base < 4 && n < 40) begin
        step(1, 0, 0, (n >= 3), pack(pushes - base + 1, 0, 0, 0, 0));
        n++;
      end
      chk("bp_all_accepted", pushes - base, 4);
    end
    repeat (4) step(0, 0, 0, 1, d);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, (NUM_IN*WIDTH)'($urandom));
    end
    repeat (4) step(0, 0, 0, 1, d);

    // Reset with two items in flight and a non-default select
    d = pack(1, 2, 3, 4, 5);
    step(0, 1, 4, 1, d);
    step(1, 0, 0, 0, d);
    step(1, 0, 0, 0, d);
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_in_ready", in_ready, 1);
    q_data.delete();
    q_t.delete();
    sel_m = DEFAULT_SEL;
    err_m = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 1, d);
    step(1, 0, 0, 1, d);
    repeat (4) step(0, 0, 0, 1, d);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

`default_nettype wire
